// File: rtl/lut_sweep_pkg.sv
// Shared types and constants for the exhaustive LUT sweep controller.
package lut_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned EXP_OR  = 0;
  localparam int unsigned EXP_AND = 1;
  localparam int unsigned EXP_XOR = 2;
  localparam int unsigned EXP_NOR = 3;

  localparam int unsigned DRAIN_CYCLES = 2;

endpackage

// File: rtl/lut_expect.sv
// Combinational reference function for the LUT under test, selected by EXP_MODE.
module lut_expect
  import lut_sweep_pkg::*;
#(
  parameter int unsigned N_IN     = 10,
  parameter int unsigned EXP_MODE = EXP_OR
) (
  input  logic [N_IN-1:0] addr,
  output logic            exp_bit
);

  generate
    if (EXP_MODE == EXP_OR) begin : g_or
      assign exp_bit = |addr;
    end else if (EXP_MODE == EXP_AND) begin : g_and
      assign exp_bit = &addr;
    end else if (EXP_MODE == EXP_XOR) begin : g_xor
      assign exp_bit = ^addr;
    end else if (EXP_MODE == EXP_NOR) begin : g_nor
      assign exp_bit = ~|addr;
    end else begin : g_bad
      $error("lut_expect: unsupported EXP_MODE %0d", EXP_MODE);
      assign exp_bit = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/lut_sweep_ctrl.sv
// Walks every LUT address once, samples the LUT through a two-stage pipeline
// and accumulates ones, mismatches and the first failing address.
module lut_sweep_ctrl
  import lut_sweep_pkg::*;
#(
  parameter int unsigned N_IN     = 10,
  parameter int unsigned EXP_MODE = EXP_OR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] lut_i,
  input  logic            lut_o,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   ones_cnt,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_err_addr,
  output logic            first_err_valid
);

  localparam int unsigned CW = N_IN + 1;
  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [N_IN-1:0] ADDR_LAST = {N_IN{1'b1}};

  state_e          state_q, state_d;
  logic [N_IN-1:0] addr_q, addr_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            s1_valid_q, s1_valid_d;
  logic            s1_bit_q, s1_bit_d;
  logic [N_IN-1:0] s1_addr_q, s1_addr_d;
  logic [CW-1:0]   ones_q, ones_d;
  logic [CW-1:0]   err_q, err_d;
  logic [N_IN-1:0] ferr_addr_q, ferr_addr_d;
  logic            ferr_valid_q, ferr_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            exp_bit;

  lut_expect #(
    .N_IN     (N_IN),
    .EXP_MODE (EXP_MODE)
  ) u_expect (
    .addr    (s1_addr_q),
    .exp_bit (exp_bit)
  );

  // Next-state, pipeline and counter logic.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    drain_d      = drain_q;
    s1_valid_d   = 1'b0;
    s1_bit_d     = lut_o;
    s1_addr_d    = addr_q;
    ones_d       = ones_q;
    err_d        = err_q;
    ferr_addr_d  = ferr_addr_q;
    ferr_valid_d = ferr_valid_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;

    // Stage 2: account the address captured on the previous edge.
    if (s1_valid_q && !abort) begin
      if (s1_bit_q) ones_d = ones_q + CW'(1);
      if (s1_bit_q != exp_bit) begin
        err_d = err_q + CW'(1);
        if (!ferr_valid_q) begin
          ferr_addr_d  = s1_addr_q;
          ferr_valid_d = 1'b1;
        end
      end
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !abort) begin
          state_d      = ST_RUN;
          addr_d       = '0;
          ones_d       = '0;
          err_d        = '0;
          ferr_addr_d  = '0;
          ferr_valid_d = 1'b0;
          pass_d       = 1'b0;
          done_d       = 1'b0;
          busy_d       = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          s1_valid_d = 1'b1;
          if (addr_q == ADDR_LAST) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end else begin
            addr_d = addr_q + N_IN'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      drain_q      <= '0;
      s1_valid_q   <= 1'b0;
      s1_bit_q     <= 1'b0;
      s1_addr_q    <= '0;
      ones_q       <= '0;
      err_q        <= '0;
      ferr_addr_q  <= '0;
      ferr_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      drain_q      <= drain_d;
      s1_valid_q   <= s1_valid_d;
      s1_bit_q     <= s1_bit_d;
      s1_addr_q    <= s1_addr_d;
      ones_q       <= ones_d;
      err_q        <= err_d;
      ferr_addr_q  <= ferr_addr_d;
      ferr_valid_q <= ferr_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign lut_i           = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign ones_cnt        = ones_q;
  assign err_cnt         = err_q;
  assign first_err_addr  = ferr_addr_q;
  assign first_err_valid = ferr_valid_q;

endmodule

// File: tb/tb_lut_sweep_ctrl.sv
// Scoreboard bench for lut_sweep_ctrl driving a behavioural OR LUT with injectable faults.
module tb_lut_sweep_ctrl;

  localparam int unsigned N_IN = 10;
  localparam int unsigned NADDR = 1 << N_IN;
  localparam int DONE_EDGE = NADDR + 2;

  typedef struct {
    int ones;
    int err;
    int faddr;
    bit fvalid;
    bit pass;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [N_IN-1:0] lut_i;
  logic            lut_o;
  logic            busy, done, pass, first_err_valid;
  logic [N_IN:0]   ones_cnt, err_cnt;
  logic [N_IN-1:0] first_err_addr;

  int   lut_mode = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  lut_sweep_ctrl #(.N_IN(N_IN), .EXP_MODE(0)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .lut_i           (lut_i),
    .lut_o           (lut_o),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .ones_cnt        (ones_cnt),
    .err_cnt         (err_cnt),
    .first_err_addr  (first_err_addr),
    .first_err_valid (first_err_valid)
  );

  always #5 clk = ~clk;

  // LUT under test: 0 = good OR, 1 = stuck-at-0, 2 = stuck-at-1, 3 = OR with address 700 flipped.
  function automatic logic lut_fn(input int mode, input logic [N_IN-1:0] a);
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return (|a) ^ (a == N_IN'(700));
      default: return |a;
    endcase
  endfunction

  always_comb lut_o = lut_fn(lut_mode, lut_i);

  function automatic exp_t model(input int mode);
    exp_t e;
    logic [N_IN-1:0] a;
    logic b;
    e = '{ones: 0, err: 0, faddr: 0, fvalid: 1'b0, pass: 1'b0};
    for (int i = 0; i < int'(NADDR); i++) begin
      a = N_IN'(i);
      b = lut_fn(mode, a);
      if (b) e.ones++;
      if (b != (|a)) begin
        e.err++;
        if (!e.fvalid) begin
          e.fvalid = 1'b1;
          e.faddr  = i;
        end
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  task automatic run_sweep(input int mode, input bit spam, input string name);
    exp_t e;
    int   edge_n;
    int   seq_bad;
    int   exp_addr;
    lut_mode = mode;
    sb_q.push_back(model(mode));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0 || lut_i !== '0) begin
      n_fail++;
      $display("FAIL %s_accept: busy=%b done=%b lut_i=%0d, expected busy=1 done=0 lut_i=0",
               name, busy, done, lut_i);
    end
    edge_n  = 0;
    seq_bad = 0;
    while (done !== 1'b1 && edge_n < 1200) begin
      if (spam) start = (edge_n % 50 == 10);
      @(posedge clk);
      #1;
      edge_n++;
      if (done !== 1'b1) begin
        exp_addr = (edge_n < int'(NADDR)) ? edge_n : int'(NADDR) - 1;
        if (lut_i !== N_IN'(exp_addr) || busy !== 1'b1) seq_bad++;
      end
    end
    start = 1'b0;
    n_tests++;
    if (edge_n != DONE_EDGE) begin
      n_fail++;
      $display("FAIL %s_latency: done at edge %0d, expected %0d", name, edge_n, DONE_EDGE);
    end
    n_tests++;
    if (seq_bad != 0) begin
      n_fail++;
      $display("FAIL %s_addr_seq: %0d bad address/busy samples, expected 0", name, seq_bad);
    end
    e = sb_q.pop_front();
    n_tests++;
    if (ones_cnt !== (N_IN+1)'(e.ones)) begin
      n_fail++;
      $display("FAIL %s_ones: got %0d expected %0d", name, ones_cnt, e.ones);
    end
    n_tests++;
    if (err_cnt !== (N_IN+1)'(e.err)) begin
      n_fail++;
      $display("FAIL %s_err: got %0d expected %0d", name, err_cnt, e.err);
    end
    n_tests++;
    if (first_err_addr !== N_IN'(e.faddr) || first_err_valid !== e.fvalid) begin
      n_fail++;
      $display("FAIL %s_first_err: got addr=%0d valid=%b expected addr=%0d valid=%b",
               name, first_err_addr, first_err_valid, e.faddr, e.fvalid);
    end
    n_tests++;
    if (pass !== e.pass || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pass: got pass=%b busy=%b expected pass=%b busy=0",
               name, pass, busy, e.pass);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_tests++;
    if ({lut_i, busy, done, pass, ones_cnt, err_cnt, first_err_addr, first_err_valid} !== '0) begin
      n_fail++;
      $display("FAIL %s: lut_i=%0d busy=%b done=%b pass=%b ones=%0d err=%0d faddr=%0d fvalid=%b, expected all 0",
               name, lut_i, busy, done, pass, ones_cnt, err_cnt, first_err_addr, first_err_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
  endtask

  task automatic test_or_sweep();
    run_sweep(0, 1'b0, "or_good");
  endtask

  task automatic test_start_abort();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b1 || lut_i !== N_IN'(NADDR - 1) || ones_cnt !== (N_IN+1)'(NADDR - 1)) begin
      n_fail++;
      $display("FAIL start_abort: busy=%b done=%b lut_i=%0d ones=%0d expected busy=0 done=1 lut_i=%0d ones=%0d",
               busy, done, lut_i, ones_cnt, NADDR - 1, NADDR - 1);
    end
  endtask

  task automatic test_faults();
    run_sweep(1, 1'b0, "stuck0");
    run_sweep(2, 1'b0, "stuck1");
    run_sweep(3, 1'b0, "flip700");
  endtask

  task automatic test_abort();
    lut_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k < 300; k++) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || lut_i !== N_IN'(299)) begin
      n_fail++;
      $display("FAIL abort_edge: busy=%b done=%b pass=%b lut_i=%0d expected 0 0 0 299",
               busy, done, pass, lut_i);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || lut_i !== N_IN'(299)) begin
      n_fail++;
      $display("FAIL abort_frozen: busy=%b lut_i=%0d expected busy=0 lut_i=299", busy, lut_i);
    end
    run_sweep(0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    run_sweep(3, 1'b1, "busy_start");
    run_sweep(0, 1'b0, "restart_done");
  endtask

  task automatic test_reset_mid();
    lut_mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k < 500; k++) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("reset_mid");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_mid_idle");
  endtask

  initial begin
    test_reset();
    test_or_sweep();
    test_start_abort();
    test_faults();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
